// File: rtl/serial_alu_seq.sv
// rtl/serial_alu_seq.sv - bit-serial sequencer driving a 1-bit ALU slice LSB first
module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_overflow,
  output logic             out_zero,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic             slice_sub,
  output logic [2:0]       slice_op,
  input  logic             slice_result,
  input  logic             slice_cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_ARITH = 3'b100;
  localparam logic [2:0] OP_SLT   = 3'b101;

  logic [1:0]       state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [2:0]       op_reg;
  logic             sub_eff;
  logic             carry;
  logic [WIDTH-1:0] res_reg;

  logic             accept_sub;
  logic             is_arith;
  logic             is_slt;
  logic             is_void;
  logic             ovf_raw;
  logic [WIDTH-1:0] full_res;
  logic [WIDTH-1:0] fin_res;
  logic             fin_cout;
  logic             fin_ovf;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign out_result = res_reg;

  // SLT always subtracts; ADD/SUB subtracts only when asked
  assign accept_sub = (in_op == OP_SLT) | ((in_op == OP_ARITH) & in_sub);

  // Slice drive: subtraction is B inverted plus a seeded carry, so the Sub pin stays low
  always_comb begin
    slice_a   = a_reg[bit_cnt];
    slice_b   = b_reg[bit_cnt] ^ sub_eff;
    slice_cin = carry;
    slice_sub = 1'b0;
    slice_op  = (op_reg[2:1] == 2'b10) ? OP_ARITH : op_reg;
  end

  // Final result/flag assembly, evaluated while the MSB is on the slice
  always_comb begin
    is_arith = (op_reg == OP_ARITH) || (op_reg == OP_SLT);
    is_slt   = (op_reg == OP_SLT);
    is_void  = (op_reg[2:1] == 2'b11);
    // carry still holds the carry into the MSB here, so no separate cin_msb register is needed
    ovf_raw  = carry ^ slice_cout;
    full_res = res_reg;
    full_res[WIDTH-1] = slice_result;
    fin_res  = full_res;
    fin_cout = 1'b0;
    fin_ovf  = 1'b0;
    if (is_arith) begin
      fin_cout = slice_cout;
      fin_ovf  = ovf_raw;
    end
    if (is_slt) begin
      fin_res = {{(WIDTH-1){1'b0}}, full_res[WIDTH-1] ^ ovf_raw};
    end
    if (is_void) begin
      fin_res = '0;
    end
  end

  // Sequencer state: accept, one slice bit per clock, hold result until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= '0;
      sub_eff      <= 1'b0;
      carry        <= 1'b0;
      res_reg      <= '0;
      out_cout     <= 1'b0;
      out_overflow <= 1'b0;
      out_zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= in_a;
            b_reg        <= in_b;
            op_reg       <= in_op;
            sub_eff      <= accept_sub;
            carry        <= accept_sub;
            bit_cnt      <= '0;
            res_reg      <= '0;
            out_cout     <= 1'b0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
            state        <= RUN;
          end
        end
        RUN: begin
          res_reg[bit_cnt] <= slice_result;
          carry            <= slice_cout;
          bit_cnt          <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            res_reg      <= fin_res;
            out_cout     <= fin_cout;
            out_overflow <= fin_ovf;
            out_zero     <= (fin_res == '0);
            bit_cnt      <= '0;
            state        <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
